// File: rtl/ascii_scroll_ctrl.sv
// ascii_scroll_ctrl: scrolls a latched ASCII message across a seven-segment ASCII display driver.
// Define ASCII_SCROLL_LOOP_EN to repeat passes until stop/reset; by default one pass per start.
module ascii_scroll_ctrl #(
   parameter int STEP_CYCLES   = 50_000_000,
   parameter int HOLD_STEPS    = 2,
   parameter int MSG_CHARS     = 16,
   parameter int DISPLAY_COUNT = 8,
   localparam int LEN_W  = $clog2(MSG_CHARS + 1),
   localparam int POS_W  = $clog2(MSG_CHARS + DISPLAY_COUNT),
   localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1,
   localparam int HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       stop,
   input  logic [8*MSG_CHARS-1:0]     msg,
   input  logic [LEN_W-1:0]           msg_len,
   output logic [8*DISPLAY_COUNT-1:0] values,
   output logic [DISPLAY_COUNT-1:0]   display_enable,
   output logic                       busy,
   output logic                       pass_done
);

`ifdef ASCII_SCROLL_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

   state_t                   state, nxt_state;
   logic [POS_W-1:0]         pos, nxt_pos;
   logic [STEP_W-1:0]        step_cnt, nxt_step;
   logic [HOLD_W-1:0]        hold_cnt, nxt_hold;
   logic [8*MSG_CHARS-1:0]   msg_q, nxt_msg;
   logic [LEN_W-1:0]         len_q, nxt_len;
   logic                     nxt_pass;
   logic                     tick;
   logic                     last_pos;
   logic                     valid_start;
   logic [8*DISPLAY_COUNT-1:0] nxt_values;

   always_comb begin
      tick        = (step_cnt == STEP_W'(STEP_CYCLES - 1));
      last_pos    = (int'(pos) == int'(len_q) + DISPLAY_COUNT - 1);
      valid_start = start && (msg_len != '0) && (int'(msg_len) <= MSG_CHARS);
      nxt_state   = state;
      nxt_pos     = pos;
      nxt_step    = step_cnt;
      nxt_hold    = hold_cnt;
      nxt_msg     = msg_q;
      nxt_len     = len_q;
      nxt_pass    = 1'b0;

      if (stop) begin
         if (state != IDLE) begin
            nxt_state = IDLE;
            nxt_pos   = '0;
            nxt_step  = '0;
            nxt_hold  = '0;
         end
      end else if (valid_start) begin
         nxt_state = HOLD;
         nxt_msg   = msg;
         nxt_len   = msg_len;
         nxt_pos   = '0;
         nxt_step  = '0;
         nxt_hold  = '0;
      end else if (state != IDLE) begin
         nxt_step = tick ? '0 : step_cnt + 1'b1;
         if (tick) begin
            if (state == HOLD) begin
               if (hold_cnt == HOLD_W'(HOLD_STEPS)) begin
                  nxt_state = RUN;
                  nxt_pos   = POS_W'(1);
                  nxt_hold  = '0;
               end else begin
                  nxt_hold = hold_cnt + 1'b1;
               end
            end else if (last_pos) begin
               nxt_pass  = 1'b1;
               nxt_pos   = '0;
               nxt_hold  = '0;
               nxt_state = LOOP_EN ? HOLD : IDLE;
            end else begin
               nxt_pos = pos + 1'b1;
            end
         end
      end
   end

   // Window render from the next position so values change on the same edge as the state.
   // Since pos + column < 2*tape_len, one conditional subtract replaces the modulo.
   always_comb begin
      int tape_len;
      int idx;
      logic [7:0] ch;
      nxt_values = {DISPLAY_COUNT{8'h20}};
      tape_len   = int'(nxt_len) + DISPLAY_COUNT;
      for (int c = 0; c < DISPLAY_COUNT; c++) begin
         idx = int'(nxt_pos) + c;
         if (idx >= tape_len) idx = idx - tape_len;
         ch = 8'h20;
         if (nxt_state != IDLE && idx < int'(nxt_len))
            ch = nxt_msg[8*(int'(nxt_len) - 1 - idx) +: 8];
         nxt_values[8*(DISPLAY_COUNT - 1 - c) +: 8] = ch;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         pos            <= '0;
         step_cnt       <= '0;
         hold_cnt       <= '0;
         msg_q          <= '0;
         len_q          <= '0;
         values         <= {DISPLAY_COUNT{8'h20}};
         display_enable <= '0;
         busy           <= 1'b0;
         pass_done      <= 1'b0;
      end else begin
         state          <= nxt_state;
         pos            <= nxt_pos;
         step_cnt       <= nxt_step;
         hold_cnt       <= nxt_hold;
         msg_q          <= nxt_msg;
         len_q          <= nxt_len;
         values         <= nxt_values;
         display_enable <= {DISPLAY_COUNT{nxt_state != IDLE}};
         busy           <= (nxt_state != IDLE);
         pass_done      <= nxt_pass;
      end
   end

endmodule

// File: tb/tb_ascii_scroll_ctrl.sv
// Testbench for ascii_scroll_ctrl: two instances (STEP=4/HOLD=1 and STEP=1/HOLD=0) checked
// every cycle against a time-based tape model, plus directed scenarios and random traffic.
module tb_ascii_scroll_ctrl;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [127:0] msg = '0;
   logic [4:0]   msg_len = '0;

   logic [63:0]  values_a, values_b;
   logic [7:0]   en_a, en_b;
   logic         busy_a, busy_b, pd_a, pd_b;

`ifdef ASCII_SCROLL_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   ascii_scroll_ctrl #(.STEP_CYCLES(4), .HOLD_STEPS(1), .MSG_CHARS(16), .DISPLAY_COUNT(8)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .msg(msg), .msg_len(msg_len),
      .values(values_a), .display_enable(en_a), .busy(busy_a), .pass_done(pd_a)
   );

   ascii_scroll_ctrl #(.STEP_CYCLES(1), .HOLD_STEPS(0), .MSG_CHARS(16), .DISPLAY_COUNT(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .msg(msg), .msg_len(msg_len),
      .values(values_b), .display_enable(en_b), .busy(busy_b), .pass_done(pd_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   // Model: each instance is either inactive, or t cycles into the current pass of its message.
   bit         m_active [2];
   bit         m_pass   [2];
   int         m_t      [2];
   int         m_len    [2];
   logic [7:0] m_chars  [2][16];

   function automatic int step_of(int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int hold_of(int i);
      return (i == 0) ? 1 : 0;
   endfunction

   function automatic int pass_cycles(int i);
      return (1 + hold_of(i)) * step_of(i) + (m_len[i] + 8 - 1) * step_of(i);
   endfunction

   function automatic int model_pos(int i);
      int h;
      h = (1 + hold_of(i)) * step_of(i);
      if (m_t[i] < h) return 0;
      return 1 + (m_t[i] - h) / step_of(i);
   endfunction

   function automatic logic [63:0] model_screen(int i);
      logic [63:0] scr;
      int p, tl, idx;
      scr = {8{8'h20}};
      if (m_active[i]) begin
         p  = model_pos(i);
         tl = m_len[i] + 8;
         for (int c = 0; c < 8; c++) begin
            idx = (p + c) % tl;
            if (idx < m_len[i]) scr[8*(7-c) +: 8] = m_chars[i][idx];
         end
      end
      return scr;
   endfunction

   task automatic model_edge(bit st, bit sp, logic [127:0] m, int len);
      for (int i = 0; i < 2; i++) begin
         m_pass[i] = 1'b0;
         if (sp) begin
            m_active[i] = 1'b0;
         end else if (st && len >= 1 && len <= 16) begin
            m_len[i] = len;
            for (int t = 0; t < len; t++) m_chars[i][t] = m[8*(len-1-t) +: 8];
            m_active[i] = 1'b1;
            m_t[i] = 0;
         end else if (m_active[i]) begin
            m_t[i]++;
            if (m_t[i] == pass_cycles(i)) begin
               m_pass[i] = 1'b1;
               if (LOOP) m_t[i] = 0;
               else      m_active[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
      n_checks++;
      if (observed === expected) n_pass++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
   endtask

   task automatic check_all();
      checkOutput("a.values", values_a, model_screen(0));
      checkOutput("a.enable", en_a, m_active[0] ? 8'hFF : 8'h00);
      checkOutput("a.busy", busy_a, m_active[0]);
      checkOutput("a.pass_done", pd_a, m_pass[0]);
      checkOutput("b.values", values_b, model_screen(1));
      checkOutput("b.enable", en_b, m_active[1] ? 8'hFF : 8'h00);
      checkOutput("b.busy", busy_b, m_active[1]);
      checkOutput("b.pass_done", pd_b, m_pass[1]);
   endtask

   task automatic applyStimulus(bit st, bit sp, logic [127:0] m, int len);
      start   = st;
      stop    = sp;
      msg     = m;
      msg_len = 5'(len);
      @(posedge clk);
      #1;
      model_edge(st, sp, m, len);
      start = 1'b0;
      stop  = 1'b0;
      check_all();
   endtask

   task automatic idle_cycles(int n);
      repeat (n) applyStimulus(1'b0, 1'b0, msg, int'(msg_len));
   endtask

   logic [127:0] elo  = "ELO212";
   logic [127:0] hans = "Hans";
   logic [127:0] m16  = "ABCDEFGHIJKLMNOP";
   logic [127:0] rmsg;
   int pd_count;

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 1'b0;
         m_pass[i]   = 1'b0;
         m_t[i]      = 0;
         m_len[i]    = 0;
      end

      #1 reset_n = 1'b0;
      #2;
      checkOutput("reset.values", values_a, {8{8'h20}});
      checkOutput("reset.enable", en_a, 8'h00);
      checkOutput("reset.busy", busy_a, 1'b0);
      checkOutput("reset.pass_done", pd_a, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Basic scroll of "ELO212"
      applyStimulus(1'b1, 1'b0, elo, 6);
      checkOutput("basic.p0", values_a, "ELO212  ");
      checkOutput("basic.enable", en_a, 8'hFF);
      idle_cycles(7);
      checkOutput("basic.p0_end", values_a, "ELO212  ");
      idle_cycles(1);
      checkOutput("basic.p1", values_a, "LO212   ");
      idle_cycles(24);
      checkOutput("basic.p7", values_a, "       E");
      idle_cycles(24);
      checkOutput("basic.p13", values_a, " ELO212 ");
      idle_cycles(3);
      checkOutput("basic.no_early_pass", pd_a, 1'b0);
      idle_cycles(1);
      checkOutput("basic.pass_at_60", pd_a, 1'b1);
      if (LOOP) begin
         checkOutput("loop.home", values_a, "ELO212  ");
         checkOutput("loop.busy", busy_a, 1'b1);
         idle_cycles(60);
         checkOutput("loop.pass2", pd_a, 1'b1);
      end else begin
         checkOutput("oneshot.blank", values_a, {8{8'h20}});
         checkOutput("oneshot.busy", busy_a, 1'b0);
         checkOutput("oneshot.enable", en_a, 8'h00);
      end
      applyStimulus(1'b0, 1'b1, elo, 6);
      checkOutput("stop.busy", busy_a, 1'b0);

      // Restart with a new message mid-RUN
      applyStimulus(1'b1, 1'b0, elo, 6);
      idle_cycles(20);
      applyStimulus(1'b1, 1'b0, hans, 4);
      checkOutput("restart.p0", values_a, "Hans    ");
      idle_cycles(7);
      checkOutput("restart.p0_end", values_a, "Hans    ");
      idle_cycles(1);
      checkOutput("restart.p1", values_a, "ans     ");

      // Asynchronous reset in the middle of RUN
      idle_cycles(5);
      reset_n = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) m_active[i] = 1'b0;
      checkOutput("midreset.values", values_a, {8{8'h20}});
      checkOutput("midreset.enable", en_a, 8'h00);
      checkOutput("midreset.busy", busy_a, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b1, 1'b0, elo, 6);
      checkOutput("after_reset.start", values_a, "ELO212  ");

      // Simultaneous start and stop: stop wins
      idle_cycles(3);
      applyStimulus(1'b1, 1'b1, hans, 4);
      checkOutput("start_stop.busy", busy_a, 1'b0);

      // Invalid lengths are ignored
      applyStimulus(1'b1, 1'b0, elo, 0);
      checkOutput("len0.busy", busy_a, 1'b0);
      applyStimulus(1'b1, 1'b0, m16, 17);
      checkOutput("len17.busy", busy_a, 1'b0);
      applyStimulus(1'b1, 1'b0, elo, 6);
      idle_cycles(3);
      applyStimulus(1'b1, 1'b0, hans, 0);
      checkOutput("len0_busy.ignored", values_a, "ELO212  ");

      // Full-length message on the fast instance: pass every 24 cycles
      applyStimulus(1'b0, 1'b1, elo, 6);
      applyStimulus(1'b1, 1'b0, m16, 16);
      checkOutput("len16.p0", values_b, "ABCDEFGH");
      pd_count = 0;
      for (int k = 0; k < 48; k++) begin
         idle_cycles(1);
         if (k == 0) checkOutput("len16.p1", values_b, "BCDEFGHI");
         if (pd_b) pd_count++;
      end
      checkOutput("len16.pass_count", pd_count, LOOP ? 2 : 1);
      applyStimulus(1'b0, 1'b1, elo, 6);

      // Random traffic, msg bus churning every cycle
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 16; b++) rmsg[8*b +: 8] = 8'($urandom_range(32, 126));
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0,
                       rmsg, int'($urandom_range(0, 17)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
